// File: rtl/multi_cycle_data_path_if.sv
// Instruction and data memory req/ready buses of the multi-cycle core.
// master = core side, slave = memory side.
interface multi_cycle_data_path_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [N-1:0]      imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [2:0]        dmem_funct3;
  logic [N-1:0]      dmem_wdata;
  logic              dmem_ready;
  logic [N-1:0]      dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_funct3, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_funct3, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/multi_cycle_data_path.sv
// Multi-cycle RV32I datapath (FETCH/DECODE/EXEC/MEM/WB) with stalling req/ready memories.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counter outputs.
module multi_cycle_data_path #(
  parameter int                N        = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ALUsrc,
  input  logic         memToReg,
  input  logic         mem_write,
  input  logic         reg_write,
  input  logic [3:0]   alu_ctrl,
  input  logic         pc_sel,
  output logic [N-1:0] inst,
  output logic         zero,
  output logic         lessSigend,
  output logic         lessUnsigend,
  output logic         retire,
  output logic [2:0]   state,
`ifdef MC_PERF_CNT_EN
  output logic [63:0]  cycle_cnt,
  output logic [63:0]  instret_cnt,
`endif
  multi_cycle_data_path_if.master bus
);
  typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                            S_MEM = 3'd3, S_WB = 3'd4} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_IMM   = 7'b0010011, OP_BRANCH = 7'b1100011,
                         OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_AUIPC = 7'b0010111, OP_LUI   = 7'b0110111;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] pc_q, next_pc;
  logic [N-1:0]      ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic              zero_q, lt_s_q, lt_u_q, we_q, retire_q;
  logic              retire_n;
  logic [N-1:0]      rf [32];
  logic [N-1:0]      rdata1, rdata2, wb_data, op2, alu_res, imm_w;
  logic [31:0]       imm32;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] imm_a, pc_plus4;

  assign opcode   = ir_q[6:0];
  assign imm_a    = ADDR_W'(imm_q);
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STORE:                 imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {ir_q[31:12], 12'b0};
      OP_JAL: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
  end
  assign imm_w = N'(imm32);

  // x0 reads as zero; writes to it are discarded at the write port
  assign rdata1 = (ir_q[19:15] == 5'd0) ? '0 : rf[ir_q[19:15]];
  assign rdata2 = (ir_q[24:20] == 5'd0) ? '0 : rf[ir_q[24:20]];

  always_ff @(posedge clk) begin
    if (reg_write && (state_q == S_WB) && (ir_q[11:7] != 5'd0))
      rf[ir_q[11:7]] <= wb_data;
  end

  assign op2 = ALUsrc ? imm_q : b_q;
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      4'd0:    alu_res = a_q + op2;
      4'd1:    alu_res = a_q - op2;
      4'd2:    alu_res = a_q & op2;
      4'd3:    alu_res = a_q | op2;
      4'd4:    alu_res = a_q ^ op2;
      4'd5:    alu_res = a_q << op2[4:0];
      4'd6:    alu_res = a_q >> op2[4:0];
      4'd7:    alu_res = $signed(a_q) >>> op2[4:0];
      4'd8:    alu_res = {{(N-1){1'b0}}, $signed(a_q) < $signed(op2)};
      4'd9:    alu_res = {{(N-1){1'b0}}, a_q < op2};
      4'd15:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    if (opcode == OP_AUIPC)                          wb_data = N'(pc_q + imm_a);
    else if (opcode == OP_JAL || opcode == OP_JALR)  wb_data = N'(pc_plus4);
    else                                             wb_data = memToReg ? mdr_q : aluout_q;
  end

  always_comb begin
    if (opcode == OP_JALR)             next_pc = (ADDR_W'(a_q) + imm_a) & ~ADDR_W'(1);
    else if (opcode == OP_JAL || pc_sel) next_pc = pc_q + imm_a;
    else                               next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    retire_n = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.imem_ready) state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_n  = we_q ? S_FETCH : S_WB;
          retire_n = we_q;
        end
      end
      S_WB: begin
        state_n  = S_FETCH;
        retire_n = 1'b1;
      end
      default:  state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      {ir_q, a_q, b_q, imm_q, aluout_q, mdr_q} <= '0;
      {zero_q, lt_s_q, lt_u_q, we_q, retire_q} <= '0;
    end else begin
      retire_q <= retire_n;
      if (retire_n) pc_q <= next_pc;
      case (state_q)
        S_FETCH:  if (bus.imem_ready) ir_q <= bus.imem_rdata;
        S_DECODE: begin
          a_q   <= rdata1;
          b_q   <= rdata2;
          imm_q <= imm_w;
        end
        S_EXEC: begin
          aluout_q <= alu_res;
          zero_q   <= (alu_res == '0);
          lt_s_q   <= $signed(a_q) < $signed(op2);
          lt_u_q   <= a_q < op2;
          // store/load decision captured here so MEM outputs depend on state only
          we_q     <= mem_write;
        end
        S_MEM:    if (bus.dmem_ready && !we_q) mdr_q <= bus.dmem_rdata;
        default:  ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire_q) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

  assign inst            = ir_q;
  assign zero            = zero_q;
  assign lessSigend      = lt_s_q;
  assign lessUnsigend    = lt_u_q;
  assign retire          = retire_q;
  assign state           = state_q;
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.dmem_req    = (state_q == S_MEM);
  assign bus.dmem_we     = we_q && (state_q == S_MEM);
  assign bus.dmem_addr   = ADDR_W'(aluout_q);
  assign bus.dmem_funct3 = ir_q[14:12];
  assign bus.dmem_wdata  = b_q;
endmodule

// File: tb/tb_multi_cycle_data_path.sv
// Scoreboard bench for multi_cycle_data_path: directed programs, queued expected retires/stores.
module tb_multi_cycle_data_path;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ALUsrc, memToReg, mem_write, reg_write, pc_sel;
  logic [3:0]  alu_ctrl;
  logic [31:0] inst;
  logic        zero, less_s, less_u, retire;
  logic [2:0]  state;

  multi_cycle_data_path_if #(.N(32), .ADDR_W(32)) bus ();

  multi_cycle_data_path #(.N(32), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .ALUsrc(ALUsrc), .memToReg(memToReg), .mem_write(mem_write),
    .reg_write(reg_write), .alu_ctrl(alu_ctrl), .pc_sel(pc_sel), .inst(inst), .zero(zero),
    .lessSigend(less_s), .lessUnsigend(less_u), .retire(retire), .state(state), .bus(bus)
  );

  // Controller model: ADD=0, SUB=1, PASS-op2=15
  always_comb begin
    ALUsrc = 1'b1; memToReg = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    alu_ctrl = 4'd0; pc_sel = 1'b0;
    case (inst[6:0])
      7'b0010011: reg_write = 1'b1;
      7'b0110011: begin ALUsrc = 1'b0; reg_write = 1'b1; alu_ctrl = inst[30] ? 4'd1 : 4'd0; end
      7'b0000011: begin memToReg = 1'b1; reg_write = 1'b1; end
      7'b0100011: mem_write = 1'b1;
      7'b1100011: begin
        ALUsrc = 1'b0; alu_ctrl = 4'd1;
        pc_sel = (inst[14:12] == 3'b000) ? zero : (inst[14:12] == 3'b001) ? !zero : 1'b0;
      end
      7'b1101111, 7'b1100111, 7'b0010111: reg_write = 1'b1;
      7'b0110111: begin reg_write = 1'b1; alu_ctrl = 4'd15; end
      default: ;
    endcase
  end

  // Memory models: ready after a programmable number of wait cycles
  logic [31:0] prog [0:31];
  logic [31:0] dmem [0:31];
  int iwait_n = 0, dwait_n = 0, iage = 0, dage = 0;
  assign bus.imem_ready = bus.imem_req && (iage >= iwait_n);
  assign bus.imem_rdata = prog[bus.imem_addr[6:2]];
  assign bus.dmem_ready = bus.dmem_req && (dage >= dwait_n);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[6:2]];
  always @(posedge clk) begin
    iage <= (reset || !bus.imem_req || bus.imem_ready) ? 0 : iage + 1;
    dage <= (reset || !bus.dmem_req || bus.dmem_ready) ? 0 : dage + 1;
    if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) dmem[bus.dmem_addr[6:2]] <= bus.dmem_wdata;
  end

  typedef struct { int lat; logic [31:0] pc; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  ret_t exp_ret[$];
  st_t  exp_st[$];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ret(input int lat, input logic [31:0] pc);
    ret_t r;
    r.lat = lat; r.pc = pc;
    exp_ret.push_back(r);
  endtask

  task automatic push_st(input logic [31:0] addr, input logic [31:0] data);
    st_t s;
    s.addr = addr; s.data = data;
    exp_st.push_back(s);
  endtask

  // Monitor: cycle count since reset release, checked on retire and store acceptance
  int cyc = 0, last_ret = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_ir = '0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      last_ret   = 0;
      prev_stall = 1'b0;
    end else begin
      if (retire) begin
        if (exp_ret.size() == 0) check("unexpected_retire", 64'd1, 64'd0);
        else begin
          ret_t r;
          r = exp_ret.pop_front();
          check("retire_latency", 64'(cyc - last_ret), 64'(r.lat));
          check("next_pc", 64'(bus.imem_addr), 64'(r.pc));
        end
        last_ret = cyc;
      end
      if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) begin
        if (exp_st.size() == 0) check("unexpected_store", 64'd1, 64'd0);
        else begin
          st_t s;
          s = exp_st.pop_front();
          check("store_addr", 64'(bus.dmem_addr), 64'(s.addr));
          check("store_wdata", 64'(bus.dmem_wdata), 64'(s.data));
          check("store_funct3", 64'(bus.dmem_funct3), 64'd2);
        end
      end
      if (prev_stall) begin
        check("imem_addr_hold", 64'(bus.imem_addr), 64'(prev_addr));
        check("ir_hold", 64'(inst), 64'(prev_ir));
      end
      prev_stall = bus.imem_req && !bus.imem_ready;
      prev_addr  = bus.imem_addr;
      prev_ir    = inst;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_ret.size() != 0 || exp_st.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_ret.size() != 0 || exp_st.size() != 0) begin
      check("drain_timeout", 64'(exp_ret.size() + exp_st.size()), 64'd0);
      exp_ret.delete();
      exp_st.delete();
    end
  endtask

  task automatic new_phase();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin prog[i] = 32'h0; dmem[i] = 32'h0; end
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_pc", 64'(bus.imem_addr), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_dmem_req", 64'(bus.dmem_req), 64'd0);

    // addi/sw/lw/sw/beq with zero-wait memories
    prog[0] = 32'h00500093;  // addi x1,x0,5
    prog[1] = 32'h00102423;  // sw   x1,8(x0)
    prog[2] = 32'h00802103;  // lw   x2,8(x0)
    prog[3] = 32'h00202623;  // sw   x2,12(x0)
    prog[4] = 32'hFE000CE3;  // beq  x0,x0,-8
    push_ret(4, 32'h04);
    push_ret(4, 32'h08); push_st(32'd8, 32'd5);
    push_ret(5, 32'h0C);
    push_ret(4, 32'h10); push_st(32'd12, 32'd5);
    push_ret(4, 32'h08);
    reset = 1'b0;
    wait_drain(200);

    // addi, jal to 0x40, jalr back to 0x20, store the link value
    new_phase();
    prog[0]  = 32'h02000093;  // addi x1,x0,0x20
    prog[1]  = 32'h03C0006F;  // jal  x0,+0x3C
    prog[16] = 32'h001081E7;  // jalr x3,1(x1)
    prog[8]  = 32'h00302823;  // sw   x3,16(x0)
    push_ret(4, 32'h04);
    push_ret(4, 32'h40);
    push_ret(4, 32'h20);
    push_ret(4, 32'h24); push_st(32'd16, 32'h44);
    reset = 1'b0;
    wait_drain(200);

    // three fetch wait states per instruction
    new_phase();
    prog[0] = 32'h00700093;  // addi x1,x0,7
    prog[1] = 32'h00102423;  // sw   x1,8(x0)
    iwait_n = 3;
    push_ret(7, 32'h04);
    push_ret(7, 32'h08); push_st(32'd8, 32'd7);
    reset = 1'b0;
    wait_drain(200);

    // reset while a store is stalled in MEM
    new_phase();
    iwait_n = 0;
    dwait_n = 10;
    prog[0] = 32'h00500093;  // addi x1,x0,5
    prog[1] = 32'h00102A23;  // sw   x1,20(x0)
    push_ret(4, 32'h04);
    reset = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_mem", 64'(state), 64'd3);
    @(negedge clk);
    check("mem_stalled_req", 64'(bus.dmem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dmem_req", 64'(bus.dmem_req), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_pc", 64'(bus.imem_addr), 64'd0);
    check("midrst_retire", 64'(retire), 64'd0);
    check("midrst_dmem_untouched", 64'(dmem[5]), 64'd0);
    check("midrst_queue", 64'(exp_ret.size() + exp_st.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
